// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO, read over the
// PicoRV32-style memory bus. Each bit is BAUD_DIVIDER+1 clk cycles long and is
// sampled at its centre, using the same bit timing as the console transmitter.
//
// Ports:
//   clk, resetn          single clock, synchronous active-low reset
//   enable               address-decode select
//   mem_valid/mem_ready  bus handshake; ready is a one-cycle pulse one cycle
//                        after the request is accepted
//   mem_instr, mem_wdata, mem_addr  unused
//   mem_wstrb            all zero = read; a read pops the FIFO
//   mem_rdata            {21'b0, frame_err, overrun, not_empty, data[7:0]}
//   serialIn             asynchronous serial line, idles high
module uart_rx #(
    parameter int BAUD_DIVIDER = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_instr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    input  logic        serialIn
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (BAUD_DIVIDER > 0) ? $clog2(BAUD_DIVIDER + 1) : 1;
    localparam logic [TW-1:0] T_FULL = TW'(BAUD_DIVIDER);
    localparam logic [TW-1:0] T_HALF = TW'(BAUD_DIVIDER / 2);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, rx_s_q;
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovr_q, ovr_d, fe_q, fe_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            push, fe_set, acc, rd_acc, empty, full, pop, wr_en;

    // Ignored bus inputs; decode happens outside this block.
    logic unused_bus;
    assign unused_bus = ^{mem_instr, mem_wdata, mem_addr};

    assign empty  = (count_q == '0);
    assign full   = (count_q == C_FULL);
    assign acc    = mem_valid & enable & ~ready_q;
    assign rd_acc = acc & (mem_wstrb == 4'b0000);
    assign pop    = rd_acc & ~empty;
    // A push into a full FIFO only lands if a pop frees a slot in the same cycle.
    assign wr_en  = push & (~full | pop);

    always_comb begin
        state_d  = state_q;
        timer_d  = (state_q == S_IDLE) ? timer_q : timer_q + 1'b1;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        push     = 1'b0;
        fe_set   = 1'b0;
        case (state_q)
            S_IDLE: if (!rx_s_q) begin
                timer_d = '0;
                state_d = S_START;
            end
            S_START: if (timer_q == T_HALF) begin
                if (!rx_s_q) begin
                    timer_d  = '0;
                    bitcnt_d = '0;
                    state_d  = S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: if (timer_q == T_FULL) begin
                shift_d  = {rx_s_q, shift_q[7:1]};
                timer_d  = '0;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == 4'd7) state_d = S_STOP;
            end
            S_STOP: if (timer_q == T_FULL) begin
                if (rx_s_q) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fe_set  = 1'b1;
                    state_d = S_BREAK;
                end
            end
            S_BREAK: if (rx_s_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (wr_en && !pop) count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;

        // New events win over the read-side clear.
        ovr_d = (push & full & ~pop) ? 1'b1 : (rd_acc ? 1'b0 : ovr_q);
        fe_d  = fe_set ? 1'b1 : (rd_acc ? 1'b0 : fe_q);

        ready_d = acc;
        rdata_d = '0;
        if (rd_acc)
            rdata_d = {21'b0, fe_q, ovr_q, ~empty, empty ? 8'h00 : fifo_q[rptr_q]};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            sync1_q  <= 1'b1;
            rx_s_q   <= 1'b1;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            fe_q     <= 1'b0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            sync1_q  <= serialIn;
            rx_s_q   <= sync1_q;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            fe_q     <= fe_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (resetn && wr_en) fifo_q[wptr_q] <= shift_q;
    end

    assign mem_ready = ready_q;
    assign mem_rdata = ready_q ? rdata_q : 32'h0;
endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int BD    = 15;
    localparam int DEPTH = 4;
    localparam int BIT   = BD + 1;

    logic        clk = 1'b0;
    logic        resetn, enable, mem_valid, mem_instr, serialIn;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: received bytes in arrival order plus sticky flags.
    byte unsigned mq[$];
    bit           m_ovr, m_fe;

    uart_rx #(.BAUD_DIVIDER(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .serialIn(serialIn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
    endfunction

    function automatic void model_push(input byte unsigned b);
        if (mq.size() >= DEPTH) m_ovr = 1'b1;
        else mq.push_back(b);
    endfunction

    // Returns the word a read must see, then applies the read's side effects.
    function automatic logic [31:0] model_read();
        logic [31:0] w;
        w = 32'h0;
        w[10] = m_fe;
        w[9]  = m_ovr;
        if (mq.size() > 0) begin
            w[8]   = 1'b1;
            w[7:0] = mq.pop_front();
        end
        m_ovr = 1'b0;
        m_fe  = 1'b0;
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame, one bit per BIT cycles. With rd_at >= 0 a bus read is
    // issued in cycle rd_at of the frame (154 lines its accept up with the push).
    task automatic send_frame(input byte unsigned b, input bit stop_ok,
                              input int hold_low_bits, input int rd_at);
        logic [9:0]  fr;
        logic [31:0] exp;
        exp = 32'h0;
        fr = {stop_ok, b, 1'b0};
        for (int c = 0; c < 10 * BIT; c++) begin
            @(posedge clk);
            #1;
            serialIn = fr[c / BIT];
            if (rd_at >= 0) begin
                if (c == rd_at) begin
                    mem_valid = 1'b1; enable = 1'b1; mem_wstrb = 4'h0;
                    exp = model_read();
                end else if (c == rd_at + 1) begin
                    chk("sim_rdy", {31'b0, mem_ready}, 32'h1);
                    chk("sim_data", mem_rdata, exp);
                    mem_valid = 1'b0; enable = 1'b0;
                end
            end
        end
        if (!stop_ok) begin
            m_fe = 1'b1;
            repeat (hold_low_bits * BIT) @(posedge clk);
            #1;
            serialIn = 1'b1;
            idle(2 * BIT);
        end else begin
            model_push(b);
        end
    endtask

    task automatic do_read(input string tag);
        logic [31:0] exp;
        @(posedge clk);
        #1;
        mem_valid = 1'b1; enable = 1'b1; mem_wstrb = 4'h0;
        exp = model_read();
        @(posedge clk);
        #1;
        chk({tag, "_rdy"}, {31'b0, mem_ready}, 32'h1);
        chk(tag, mem_rdata, exp);
        @(posedge clk);
        #1;
        // valid still held here: it must not be accepted a second time
        chk({tag, "_once"}, {31'b0, mem_ready}, 32'h0);
        chk({tag, "_zero"}, mem_rdata, 32'h0);
        mem_valid = 1'b0; enable = 1'b0;
    endtask

    task automatic do_write();
        @(posedge clk);
        #1;
        mem_valid = 1'b1; enable = 1'b1;
        mem_wstrb = 4'($urandom_range(1, 15));
        mem_wdata = $urandom;
        @(posedge clk);
        #1;
        chk("wr_rdy", {31'b0, mem_ready}, 32'h1);
        chk("wr_data", mem_rdata, 32'h0);
        mem_valid = 1'b0; enable = 1'b0; mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        chk("wr_once", {31'b0, mem_ready}, 32'h0);
    endtask

    initial begin
        resetn = 1'b0; serialIn = 1'b1; enable = 1'b0; mem_valid = 1'b0;
        mem_instr = 1'b0; mem_wstrb = 4'h0; mem_wdata = 32'h0; mem_addr = 32'h0;
        model_reset();
        idle(3);
        chk("rst_rdy", {31'b0, mem_ready}, 32'h0);
        chk("rst_data", mem_rdata, 32'h0);
        resetn = 1'b1;
        idle(4);
        do_read("rd_empty");

        // single byte
        send_frame(8'h55, 1'b1, 0, -1);
        do_read("rd_55");
        do_read("rd_55_after");

        // loopback-style sequence
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 0, -1);
        send_frame(8'hA5, 1'b1, 0, -1);
        for (int i = 0; i < 3; i++) do_read("rd_loop");

        // overrun: 5 bytes into 4 entries
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1);
        for (int i = 0; i < 5; i++) do_read("rd_ovr");

        // glitch shorter than half a bit is ignored
        serialIn = 1'b0;
        idle(3);
        serialIn = 1'b1;
        idle(3 * BIT);
        do_read("rd_glitch");
        send_frame(8'h5A, 1'b1, 0, -1);
        do_read("rd_after_glitch");

        // framing error followed by a long break
        send_frame(8'h3C, 1'b0, 100, -1);
        do_read("rd_break");
        do_read("rd_break_after");

        // write access leaves state alone
        send_frame(8'hC3, 1'b1, 0, -1);
        do_write();
        do_read("rd_after_wr");

        // reset in the middle of data bit 4
        for (int c = 0; c < 5 * BIT + BIT / 2; c++) begin
            @(posedge clk);
            #1;
            serialIn = (c < BIT) ? 1'b0 : c[4];
        end
        resetn = 1'b0;
        serialIn = 1'b1;
        idle(2);
        resetn = 1'b1;
        model_reset();
        chk("midrst_rdy", {31'b0, mem_ready}, 32'h0);
        idle(BIT);
        send_frame(8'h81, 1'b1, 0, -1);
        do_read("rd_81");
        do_read("rd_81_after");

        // push and pop in the same cycle with the FIFO full
        for (int i = 0; i < 4; i++) send_frame(8'(8'h11 + i), 1'b1, 0, -1);
        send_frame(8'h7E, 1'b1, 0, 154);
        idle(2);
        for (int i = 0; i < 5; i++) do_read("rd_sim");

        // randomized traffic
        for (int it = 0; it < 20; it++) begin
            int nf, nr;
            nf = $urandom_range(0, 5);
            for (int f = 0; f < nf; f++) begin
                send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 1, -1);
                idle($urandom_range(0, 20));
            end
            nr = $urandom_range(0, 5);
            for (int r = 0; r < nr; r++) do_read("rd_rand");
        end
        for (int r = 0; r < DEPTH + 1; r++) do_read("rd_drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver and the companion input stage to the console transmitter. It shares that transmitter's bit timing, so a looped-back serial line round-trips bytes unchanged. It deserialises 8N1 frames from the serial input pin, sampling each bit at its centre, and queues received bytes in a small FIFO. The PicoRV32 core reads that FIFO through the same memory-mapped bus interface used by the other peripherals.

Parameters:
BAUD_DIVIDER, 434, bit period minus one in clk cycles; one bit equals BAUD_DIVIDER+1 cycles (115200 baud at 50 MHz).
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  input  1  system clock; the block uses this single clock only.
resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
enable  input  1  address-decode select for this peripheral.
mem_valid  input  1  bus request valid.
mem_ready  output  1  bus acknowledge, one-cycle pulse.
mem_instr  input  1  instruction-fetch flag; ignored.
mem_wstrb  input  4  write strobes; all zero means the request is a read.
mem_wdata  input  32  write data; ignored.
mem_addr  input  32  address; ignored, because decode is done externally.
mem_rdata  output  32  read data.
serialIn  input  1  asynchronous serial line; idles high.

Behaviour:
- Reset (resetn low at a clk edge):
  - State goes to IDLE; timer, bit count and shift register go to 0.
  - The FIFO empties; the overrun and framing-error flags clear.
  - The synchroniser flops go to 1.
  - mem_ready=0 and mem_rdata=0.
  - Reset asserted mid-frame discards the partial byte; after release the block waits for a fresh falling edge.
- Input sync: serialIn passes through 2 flops to give rx_s. All decisions use rx_s, so there is a 2-cycle latency from the pin.
- Receive FSM, with bitTimer counting every cycle in states other than IDLE:
  - IDLE: when rx_s==0, clear bitTimer and go to START.
  - START: at bitTimer==BAUD_DIVIDER/2 (integer division):
    - If rx_s==0, the start bit is confirmed: clear bitTimer and bitCount, then go to DATA.
    - Otherwise the edge was a glitch: go to IDLE and push nothing.
  - DATA: at bitTimer==BAUD_DIVIDER, shift rx_s into the MSB of the shifter (LSB arrives first), clear bitTimer and increment bitCount. After the 8th sample, go to STOP.
  - STOP: at bitTimer==BAUD_DIVIDER, sample rx_s:
    - If 1: push the shifter into the FIFO and go to IDLE.
    - If 0: set the framing-error flag, discard the byte and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line (break) therefore produces exactly one framing error and no phantom frames.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus an occupancy count of log2(FIFO_DEPTH)+1 bits.
  - Push when full with no pop in the same cycle: the byte is dropped, the overrun flag is set, and the FIFO contents are unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This is not an overrun, even when the FIFO is full.
  - A pop when the FIFO is empty has no effect.
- Bus:
  - A request is accepted on a cycle with mem_valid & enable & !mem_ready.
  - On the next cycle mem_ready=1 for exactly 1 cycle. This gives a fixed 1-cycle latency, and a held mem_valid is never double-accepted.
  - On a read accept (mem_wstrb==0), rdata_q is registered as:
    - [7:0] FIFO head, or 0 if the FIFO is empty
    - [8] not-empty
    - [9] overrun
    - [10] framing error
    - [31:11] 0
  - In the same accept cycle the FIFO pops if it is non-empty, and the overrun and framing flags clear.
  - A flag set in the same cycle as the clear takes priority, so the new flag stays set.
  - On a write accept (any wstrb nonzero), mem_ready is still asserted, state is unchanged and rdata_q is 0.
  - mem_rdata = mem_ready ? rdata_q : 0.

Test Plan:
- BAUD_DIVIDER=15: drive frame 0x55 (start, LSB first, stop) with 16-cycle bits, then read. Required: mem_rdata=0x155, with mem_ready high for one cycle, one cycle after acceptance. A second read returns 0x000.
- Loopback: connect the transmitter's serialOut to serialIn, with both at BAUD_DIVIDER=15. Send 0x00, 0xFF and 0xA5, then read three times. Required: 0x100, 0x1FF, 0x1A5 in order.
- Receive 5 bytes (0x01..0x05) with FIFO_DEPTH=4 and no reads, then read 4 times. Required: 0x301, 0x102, 0x103, 0x104. A fifth read returns 0x000.
- Pulse serialIn low for 3 cycles while idle. Required: no FIFO push, and the state is back in IDLE after cycle BAUD_DIVIDER/2.
- Frame 0x3C with the stop bit driven low, then hold the line low for 100 bits, then idle. Required: one framing error; the read returns 0x400; no bytes are queued.
- Assert resetn low at mid-data-bit 4, release it, then send 0x81. Required: the only FIFO entry is 0x81, and the first read returns 0x181.
- With the FIFO full, push 0x7E in the same cycle a read is accepted. Required: the overrun bit stays 0, and 0x7E appears as the last of 4 entries.
